// File: rtl/door_access_ctrl.sv
// Door access front end: debounces the enter button, checks the switch code
// against SECRET, holds an open request until the door stage acknowledges, and
// locks out after repeated wrong entries.
module door_access_ctrl #(
  parameter int                CODE_W       = 4,
  parameter logic [CODE_W-1:0] SECRET       = 4'b1010,
  parameter int                DEBOUNCE_CYC = 500000,
  parameter int                MAX_FAILS    = 3,
  parameter int                DENY_CYC     = 25000000,
  parameter int                LOCK_CYC     = 250000000,
  parameter int                ACK_TIMEOUT  = 1000,
  localparam int               FAIL_W       = $clog2(MAX_FAILS + 1)
) (
  input  logic              clk,
  input  logic              rst_a_n,
  input  logic              enter_btn,
  input  logic [CODE_W-1:0] code_sw,
  input  logic              door_busy,
  output logic              open_req,
  output logic              granted,
  output logic              denied,
  output logic              locked,
  output logic [FAIL_W-1:0] fail_cnt
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int TMR_MAX = (DENY_CYC > LOCK_CYC)
                         ? ((DENY_CYC > ACK_TIMEOUT) ? DENY_CYC : ACK_TIMEOUT)
                         : ((LOCK_CYC > ACK_TIMEOUT) ? LOCK_CYC : ACK_TIMEOUT);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_SAT   = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0]  ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  DENY_LAST = TMR_W'(DENY_CYC - 1);
  localparam logic [TMR_W-1:0]  LOCK_LAST = TMR_W'(LOCK_CYC - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_DONE,
    S_DENY,
    S_LOCKOUT
  } state_t;

  logic              sync1_q, sync2_q;
  logic              db_level_q, db_level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;

  state_t            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [FAIL_W-1:0] fail_q;
  logic              open_q, granted_q, denied_q, locked_q;

  // Level flips only after DEBOUNCE_CYC consecutive mismatching cycles.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = ~db_level_q;
        press_d    = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= enter_btn;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
    end
  end

  // Outputs are loaded together with the state so they are Moore and registered.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      fail_q    <= '0;
      open_q    <= 1'b0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      timer_q <= (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_W'(1);
      case (state_q)
        S_IDLE: begin
          if (press_q && !door_busy) begin
            timer_q <= '0;
            if (code_sw == SECRET) begin
              state_q   <= S_GRANT;
              open_q    <= 1'b1;
              granted_q <= 1'b1;
              fail_q    <= '0;
            end else begin
              state_q  <= S_DENY;
              denied_q <= 1'b1;
              if (fail_q != FAIL_MAX) fail_q <= fail_q + FAIL_W'(1);
            end
          end
        end
        S_GRANT: begin
          if (door_busy) begin
            state_q <= S_WAIT_DONE;
            open_q  <= 1'b0;
            timer_q <= '0;
          end else if (timer_q == ACK_LAST) begin
            state_q   <= S_IDLE;
            open_q    <= 1'b0;
            granted_q <= 1'b0;
            timer_q   <= '0;
          end
        end
        S_WAIT_DONE: begin
          if (!door_busy) begin
            state_q   <= S_IDLE;
            granted_q <= 1'b0;
            timer_q   <= '0;
          end
        end
        S_DENY: begin
          if (timer_q == DENY_LAST) begin
            denied_q <= 1'b0;
            timer_q  <= '0;
            if (fail_q == FAIL_MAX) begin
              state_q  <= S_LOCKOUT;
              locked_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_LOCKOUT: begin
          if (timer_q == LOCK_LAST) begin
            state_q  <= S_IDLE;
            locked_q <= 1'b0;
            fail_q   <= '0;
            timer_q  <= '0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          timer_q   <= '0;
          open_q    <= 1'b0;
          granted_q <= 1'b0;
          denied_q  <= 1'b0;
          locked_q  <= 1'b0;
        end
      endcase
    end
  end

  assign open_req = open_q;
  assign granted  = granted_q;
  assign denied   = denied_q;
  assign locked   = locked_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed cycle-table bench for door_access_ctrl with short test timings;
// each row holds inputs for N cycles and the outputs expected after each edge.
module tb_door_access_ctrl;

  logic       clk;
  logic       rst_a_n;
  logic       enter_btn;
  logic [3:0] code_sw;
  logic       door_busy;
  logic       open_req;
  logic       granted;
  logic       denied;
  logic       locked;
  logic [1:0] fail_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  door_access_ctrl #(
    .CODE_W      (4),
    .SECRET      (4'b1010),
    .DEBOUNCE_CYC(4),
    .MAX_FAILS   (3),
    .DENY_CYC    (8),
    .LOCK_CYC    (20),
    .ACK_TIMEOUT (10)
  ) dut (
    .clk      (clk),
    .rst_a_n  (rst_a_n),
    .enter_btn(enter_btn),
    .code_sw  (code_sw),
    .door_busy(door_busy),
    .open_req (open_req),
    .granted  (granted),
    .denied   (denied),
    .locked   (locked),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  typedef struct {
    int         rep;
    logic       btn;
    logic [3:0] code;
    logic       busy;
    logic [5:0] exp;  // {open_req, granted, denied, locked, fail_cnt}
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] OK  = 4'b1010;
  localparam logic [3:0] BAD = 4'b0001;

  function automatic void v(int rep, logic btn, logic [3:0] code, logic busy,
                            logic o, logic g, logic d, logic l, logic [1:0] f);
    vec_t r;
    r.rep  = rep;
    r.btn  = btn;
    r.code = code;
    r.busy = busy;
    r.exp  = {o, g, d, l, f};
    vecs.push_back(r);
  endfunction

  function automatic logic [5:0] outs();
    return {open_req, granted, denied, locked, fail_cnt};
  endfunction

  task automatic check(string name, logic [5:0] got, logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (open,gr,den,lock,fail)", name, got, exp);
    end
  endtask

  initial begin
    // settle
    v(3, 0, 4'h0, 0, 0,0,0,0,2'd0);
    // correct code; code only valid on the press-evaluation cycle
    v(6, 1, 4'h0, 0, 0,0,0,0,2'd0);
    v(1, 1, OK,   0, 1,1,0,0,2'd0);
    v(2, 1, 4'h0, 0, 1,1,0,0,2'd0);
    v(15,1, 4'h0, 1, 0,1,0,0,2'd0);
    v(10,0, 4'h0, 0, 0,0,0,0,2'd0);
    // bounce on press, one evaluation, bounce on release
    v(1, 1, OK, 0, 0,0,0,0,2'd0);
    v(2, 0, OK, 0, 0,0,0,0,2'd0);
    v(3, 1, OK, 0, 0,0,0,0,2'd0);
    v(1, 0, OK, 0, 0,0,0,0,2'd0);
    v(2, 1, OK, 0, 0,0,0,0,2'd0);
    v(1, 0, OK, 0, 0,0,0,0,2'd0);
    v(6, 1, OK, 0, 0,0,0,0,2'd0);
    v(1, 1, OK, 0, 1,1,0,0,2'd0);
    v(5, 1, OK, 1, 0,1,0,0,2'd0);
    v(1, 0, OK, 0, 0,0,0,0,2'd0);
    v(1, 1, OK, 0, 0,0,0,0,2'd0);
    v(2, 0, OK, 0, 0,0,0,0,2'd0);
    v(3, 1, OK, 0, 0,0,0,0,2'd0);
    v(12,0, OK, 0, 0,0,0,0,2'd0);
    // three wrong codes -> lockout; correct press inside lockout discarded
    v(6, 1, BAD, 0, 0,0,0,0,2'd0);
    v(8, 1, BAD, 0, 0,0,1,0,2'd1);
    v(10,0, BAD, 0, 0,0,0,0,2'd1);
    v(6, 1, BAD, 0, 0,0,0,0,2'd1);
    v(8, 1, BAD, 0, 0,0,1,0,2'd2);
    v(10,0, BAD, 0, 0,0,0,0,2'd2);
    v(6, 1, BAD, 0, 0,0,0,0,2'd2);
    v(8, 1, BAD, 0, 0,0,1,0,2'd3);
    v(5, 0, OK,  0, 0,0,0,1,2'd3);
    v(15,1, OK,  0, 0,0,0,1,2'd3);
    v(5, 1, OK,  0, 0,0,0,0,2'd0);
    v(10,0, OK,  0, 0,0,0,0,2'd0);
    // two wrong, then correct with no ack -> count cleared, ack timeout
    v(6, 1, BAD, 0, 0,0,0,0,2'd0);
    v(8, 1, BAD, 0, 0,0,1,0,2'd1);
    v(10,0, BAD, 0, 0,0,0,0,2'd1);
    v(6, 1, BAD, 0, 0,0,0,0,2'd1);
    v(8, 1, BAD, 0, 0,0,1,0,2'd2);
    v(10,0, BAD, 0, 0,0,0,0,2'd2);
    v(6, 1, OK,  0, 0,0,0,0,2'd2);
    v(10,1, OK,  0, 1,1,0,0,2'd0);
    v(10,0, OK,  0, 0,0,0,0,2'd0);
    // press while door busy in IDLE is ignored and not queued
    v(16,1, OK,  1, 0,0,0,0,2'd0);
    v(10,0, OK,  0, 0,0,0,0,2'd0);

    rst_a_n   = 1'b0;
    enter_btn = 1'b0;
    code_sw   = 4'h0;
    door_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 6'b000000);
    $display("[TB] reset state checked");
    @(negedge clk);
    rst_a_n = 1'b1;

    foreach (vecs[i]) begin
      int row_fail;
      row_fail = n_fail;
      for (int c = 0; c < vecs[i].rep; c++) begin
        enter_btn = vecs[i].btn;
        code_sw   = vecs[i].code;
        door_busy = vecs[i].busy;
        @(posedge clk);
        #1;
        check($sformatf("row%0d_cyc%0d", i, c), outs(), vecs[i].exp);
      end
      $display("[TB] row %0d: btn=%b code=%b busy=%b x%0d exp=%b %s", i,
               vecs[i].btn, vecs[i].code, vecs[i].busy, vecs[i].rep, vecs[i].exp,
               (n_fail == row_fail) ? "ok" : "bad");
    end

    // asynchronous reset while in GRANT
    enter_btn = 1'b1;
    code_sw   = OK;
    door_busy = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("grant_before_reset", outs(), 6'b110000);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("async_reset_in_grant", outs(), 6'b000000);
    enter_btn = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("idle_after_reset", outs(), 6'b000000);
    end
    $display("[TB] async reset in GRANT checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
